// File: rtl/activation_pipe.sv
// activation_pipe: multi-lane fixed-point activation (Step/Sigmoid/Tanh/ReLU/identity), shift-only PLAN sigmoid.
// Latency: 3 cycles from acceptance to out_valid with out_ready held high; 1 beat/cycle throughput.
// Backpressure: each stage holds its beat while its successor is full and stalled; in_ready drops when S1 cannot move.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_act selects the function per beat, in_sum = LANES packed signed sums
//   out_valid/out_ready   output handshake; out_pred = LANES packed results, lane 0 in the low bits
//   sat_clr/sat_cnt       synchronous clear / saturating count of lanes whose PLAN argument reached 5.0
//
// Build option: define LEAKY_RELU_EN to make the ReLU negative branch return sum >>> 3 instead of 0.
// act codes: 0 Step, 1 Sigmoid, 2 Tanh, 3 ReLU, 4..7 identity.

module activation_pipe #(
    parameter int LANES = 4,
    parameter int W     = 16,
    parameter int FRAC  = 8,
    parameter int SAT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_act,
    input  logic [LANES*W-1:0] in_sum,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out_pred,
    input  logic               sat_clr,
    output logic [SAT_W-1:0]   sat_cnt
);

    localparam logic [2:0] ACT_STEP = 3'd0;
    localparam logic [2:0] ACT_SIG  = 3'd1;
    localparam logic [2:0] ACT_TANH = 3'd2;
    localparam logic [2:0] ACT_RELU = 3'd3;

    // |a| needs W+1 bits: Tanh doubles the sum before the PLAN lookup.
    localparam int AW     = W + 1;
    localparam int NW     = $clog2(LANES + 1);
    localparam int ONE_I  = 1 << FRAC;
    // Breakpoints and offsets rounded to the nearest FRAC-bit value.
    localparam int T5     = 5 * ONE_I;
    localparam int T2375  = (19 * ONE_I + 4) / 8;
    localparam int C084   = (27 * ONE_I + 16) / 32;
    localparam int C0625  = (5 * ONE_I + 4) / 8;
    localparam int C05    = ONE_I / 2;

    localparam logic [AW-1:0]         ONE_A = AW'(ONE_I);
    localparam logic signed [W+1:0]   ONE_S = (W+2)'(ONE_I);

    // Shift-only piecewise-linear sigmoid on a non-negative argument.
    function automatic logic [AW-1:0] plan(input logic [AW-1:0] x);
        if (x >= AW'(T5))         return ONE_A;
        else if (x >= AW'(T2375)) return (x >> 5) + AW'(C084);
        else if (x >= ONE_A)      return (x >> 3) + AW'(C0625);
        else                      return (x >> 2) + AW'(C05);
    endfunction

    // Final per-lane result, computed at W+2 bits and clamped back to W.
    function automatic logic [W-1:0] lane_out(input logic [2:0] act, input logic [W-1:0] s,
                                              input logic [AW-1:0] p, input logic sgn);
        logic signed [W+1:0] sx;
        logic signed [W+1:0] y;
        logic signed [W+1:0] r;
        logic                pos;
        sx  = $signed({{2{s[W-1]}}, s});
        pos = !s[W-1] && (|s);
        y   = $signed({1'b0, p});
        if (sgn) y = ONE_S - y;  // sigmoid(-x) = 1 - sigmoid(x)
        case (act)
            ACT_SIG:  r = y;
            ACT_TANH: r = (y <<< 1) - ONE_S;  // tanh(x) = 2*sigmoid(2x) - 1
            ACT_STEP: r = pos ? ONE_S : '0;
            ACT_RELU: begin
                if (pos) r = sx;
                else begin
`ifdef LEAKY_RELU_EN
                    r = sx >>> 3;
`else
                    r = '0;
`endif
                end
            end
            default:  r = sx;
        endcase
        if ((&r[W+1:W-1]) || !(|r[W+1:W-1])) return r[W-1:0];
        else return r[W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    endfunction

    // Flow control: a stage loads when it is empty or its contents move on.
    logic v1, v2, v3;
    logic en1, en2, en3;
    assign en3       = !v3 || out_ready;
    assign en2       = !v2 || en3;
    assign en1       = !v1 || en2;
    assign in_ready  = en1;
    assign out_valid = v3;

    logic [LANES-1:0][W-1:0]  sum_in, sum1, sum2;
    logic [LANES-1:0][AW-1:0] abs_c, abs1, p_c, p2;
    logic [LANES-1:0]         sgn_c, sgn1, sgn2, sat_c, sat2;
    logic [LANES-1:0][W-1:0]  res_c;
    logic [2:0]               act1, act2;
    logic [NW-1:0]            nsat_c, nsat3;

    assign sum_in = in_sum;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [AW-1:0] a;
        assign a        = (in_act == ACT_TANH) ? {sum_in[g], 1'b0} : {sum_in[g][W-1], sum_in[g]};
        assign abs_c[g] = a[AW-1] ? (~a + AW'(1)) : a;
        assign sgn_c[g] = a[AW-1];
        assign p_c[g]   = plan(abs1[g]);
        assign sat_c[g] = abs1[g] >= AW'(T5);
        assign res_c[g] = lane_out(act2, sum2[g], p2[g], sgn2[g]);
    end

    // Saturation events only count for the PLAN-based functions.
    always_comb begin
        nsat_c = '0;
        if (act2 == ACT_SIG || act2 == ACT_TANH) begin
            for (int i = 0; i < LANES; i++) nsat_c = nsat_c + NW'(sat2[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
            act1 <= '0; sum1 <= '0; abs1 <= '0; sgn1 <= '0;
            act2 <= '0; sum2 <= '0; p2 <= '0; sgn2 <= '0; sat2 <= '0;
            out_pred <= '0; nsat3 <= '0;
        end else begin
            if (en1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    act1 <= in_act; sum1 <= sum_in; abs1 <= abs_c; sgn1 <= sgn_c;
                end
            end
            if (en2) begin
                v2 <= v1;
                if (v1) begin
                    act2 <= act1; sum2 <= sum1; p2 <= p_c; sgn2 <= sgn1; sat2 <= sat_c;
                end
            end
            if (en3) begin
                v3 <= v2;
                if (v2) begin
                    out_pred <= res_c; nsat3 <= nsat_c;
                end
            end
        end
    end

    logic [SAT_W:0] sat_sum;
    assign sat_sum = {1'b0, sat_cnt} + (SAT_W+1)'(nsat3);

    // Clear has priority over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    sat_cnt <= '0;
        else if (sat_clr)              sat_cnt <= '0;
        else if (v3 && out_ready)      sat_cnt <= sat_sum[SAT_W] ? '1 : sat_sum[SAT_W-1:0];
    end

endmodule

// File: tb/tb_activation_pipe.sv
// tb_activation_pipe: directed vectors with a scoreboard queue; a negedge monitor pops on every output transfer.
// Covers the PLAN segments and breakpoints, all act codes, back-to-back mixing, backpressure,
// mid-flight reset, sat_clr priority and sat_cnt saturation.

module tb_activation_pipe;

    localparam logic [2:0] A_STEP = 3'd0;
    localparam logic [2:0] A_SIG  = 3'd1;
    localparam logic [2:0] A_TANH = 3'd2;
    localparam logic [2:0] A_RELU = 3'd3;
    localparam logic [2:0] A_ID   = 3'd4;
    localparam logic [2:0] A_ID7  = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_act;
    logic [63:0] in_sum;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pred;
    logic        sat_clr;
    logic [15:0] sat_cnt;

    always #5 clk = ~clk;

    activation_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_sum(in_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_pred(out_pred),
        .sat_clr(sat_clr), .sat_cnt(sat_cnt)
    );

    logic [63:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    // Monitor: compares every transfer against the scoreboard, and checks hold stability under stall.
    logic        held_vld = 1'b0;
    logic [63:0] held;
    logic        saw_stall = 1'b0;

    always @(negedge clk) begin
        if (in_valid && !in_ready) saw_stall = 1'b1;
        if (rst_n && out_valid) begin
            if (held_vld) chk("hold", out_pred, held);
            if (out_ready) begin
                held_vld = 1'b0;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_beat: got %h expected none", out_pred);
                end else begin
                    chk("pred", out_pred, exp_q.pop_front());
                end
            end else begin
                held_vld = 1'b1;
                held     = out_pred;
            end
        end else begin
            held_vld = 1'b0;
        end
    end

    task automatic send(input logic [2:0] act, input logic [63:0] s, input logic [63:0] e);
        int  t;
        bit  done;
        t = 0; done = 0;
        in_valid = 1'b1; in_act = act; in_sum = s;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                @(posedge clk); #1;
                done = 1;
            end else begin
                @(posedge clk); #1;
                t++;
                if (t > 200) begin
                    n_cmp++; n_err++;
                    $display("FAIL send_timeout: in_ready stuck 0 expected 1");
                    done = 1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_act = '0; in_sum = '0; out_ready = 1'b1; sat_clr = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pred",  out_pred,       64'd0);
        chk("rst_sat_cnt",   64'(sat_cnt),   64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Sigmoid with exact 3-cycle latency.
        send(A_SIG, pk(0, 256, -256, 2048), pk(128, 192, 64, 256));
        @(negedge clk); chk("lat_c1", 64'(out_valid), 64'd0);
        @(negedge clk); chk("lat_c2", 64'(out_valid), 64'd0);
        @(negedge clk); chk("lat_c3", 64'(out_valid), 64'd1);
        drain();
        chk("sat_after_sig", 64'(sat_cnt), 64'd1);

        send(A_TANH, pk(0, 256, -256, -4096), pk(0, 192, -192, -256));
        drain();
        chk("sat_after_tanh", 64'(sat_cnt), 64'd2);

        // Segment breakpoints and extreme inputs.
        send(A_SIG,  pk(1280, 1279, 608, 607),    pk(256, 255, 235, 235));
        send(A_TANH, pk(-32768, 32767, 640, -1),  pk(-256, 256, 256, 0));
        drain();
        chk("sat_after_bounds", 64'(sat_cnt), 64'd6);

`ifdef LEAKY_RELU_EN
        send(A_RELU, pk(-5, 0, 7, -32768), pk(-1, 0, 7, -4096));
`else
        send(A_RELU, pk(-5, 0, 7, -32768), pk(0, 0, 7, 0));
`endif
        send(A_STEP, pk(0, 1, -1, 32767), pk(0, 256, 0, 256));
        send(A_ID,   pk(-3, 3, 0, 100),   pk(-3, 3, 0, 100));
        send(A_ID7,  pk(-32768, 32767, 1, -1), pk(-32768, 32767, 1, -1));
        drain();

        // Mixed act codes back-to-back.
        send(A_SIG,  pk(0, 256, -256, 2048),     pk(128, 192, 64, 256));
`ifdef LEAKY_RELU_EN
        send(A_RELU, pk(-5, 0, 7, -32768), pk(-1, 0, 7, -4096));
`else
        send(A_RELU, pk(-5, 0, 7, -32768), pk(0, 0, 7, 0));
`endif
        send(A_TANH, pk(-32768, 32767, 640, -1), pk(-256, 256, 256, 0));
        send(A_STEP, pk(0, 1, -1, 32767),        pk(0, 256, 0, 256));
        send(A_ID,   pk(-3, 3, 0, 100),          pk(-3, 3, 0, 100));
        drain();
        chk("sat_after_mixed", 64'(sat_cnt), 64'd10);

        // Backpressure: out_ready toggles every cycle while 6 beats stream in.
        saw_stall = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(A_ID, pk(i, -i, 100 * i, 7), pk(i, -i, 100 * i, 7));
            end
            begin
                repeat (30) begin
                    @(posedge clk); #1;
                    out_ready = ~out_ready;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("in_ready_dropped", 64'(saw_stall), 64'd1);
        chk("sat_after_bp", 64'(sat_cnt), 64'd10);

        // sat_clr in the same cycle as a saturating output transfer.
        send(A_TANH, pk(0, 256, -256, -4096), pk(0, 192, -192, -256));
        @(posedge clk); #1;
        @(posedge clk); #1 sat_clr = 1'b1;
        @(posedge clk); #1 sat_clr = 1'b0;
        chk("sat_clr_wins", 64'(sat_cnt), 64'd0);
        chk("sat_clr_queue", 64'(exp_q.size()), 64'd0);
        send(A_TANH, pk(0, 256, -256, -4096), pk(0, 192, -192, -256));
        drain();
        chk("sat_after_clr", 64'(sat_cnt), 64'd1);

        // Reset with three beats in flight.
        send(A_TANH, pk(-4096, -4096, -4096, -4096), pk(-256, -256, -256, -256));
        send(A_TANH, pk(-4096, -4096, -4096, -4096), pk(-256, -256, -256, -256));
        send(A_TANH, pk(-4096, -4096, -4096, -4096), pk(-256, -256, -256, -256));
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_sat",   64'(sat_cnt),   64'd0);
        chk("mid_rst_pred",  out_pred,       64'd0);
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(out_valid), 64'd0);
        end

        // Counter saturation: 70000 saturating lanes in total.
        for (int i = 0; i < 16383; i++)
            send(A_SIG, pk(2048, 2048, 2048, 2048), pk(256, 256, 256, 256));
        drain();
        chk("sat_near_top", 64'(sat_cnt), 64'hFFFC);
        for (int i = 0; i < 1117; i++)
            send(A_SIG, pk(2048, 2048, 2048, 2048), pk(256, 256, 256, 256));
        drain();
        chk("sat_saturated", 64'(sat_cnt), 64'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
